// File: rtl/fsm_light_sel.sv
// N-channel switch-to-light selector: debounced switch vector drives a one-of-N
// light with explicit multi-switch error state and optional blink of the active light.
module fsm_light_sel #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned BLINK_HALF = 8,
  localparam int unsigned SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_CH-1:0]   i_OnOffSW,
  input  logic              i_mode,
  output logic [N_CH-1:0]   o_Light,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_active,
  output logic              o_err
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned POP_W = $clog2(N_CH + 1);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ON  = 2'd1,
    S_ERR = 2'd2
  } state_t;

  logic [N_CH-1:0]  r_sw_q;
  logic [N_CH-1:0]  r_sw_deb;
  logic [DEB_W-1:0] r_deb_cnt;
  state_t           r_state;
  logic [SEL_W-1:0] r_idx;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_phase;

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [BLK_W-1:0] w_blink_nxt;
  logic             w_phase_nxt;
  logic [POP_W-1:0] w_pop;
  logic [SEL_W-1:0] w_pos;
  logic             w_restart;

  // Debounce: accept the raw vector only after DEB_CYCLES stable samples.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sw_q    <= '0;
      r_deb_cnt <= DEB_MAX;
      r_sw_deb  <= '0;
    end else if (i_OnOffSW != r_sw_q) begin
      r_sw_q    <= i_OnOffSW;
      r_deb_cnt <= '0;
    end else if (r_deb_cnt < DEB_MAX) begin
      r_deb_cnt <= r_deb_cnt + DEB_W'(1);
    end else begin
      r_sw_deb  <= r_sw_q;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_OFF;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  // Next state: classify the accepted vector by its population count.
  always_comb begin
    w_state_nxt = S_OFF;
    w_idx_nxt   = '0;
    w_blink_nxt = '0;
    w_phase_nxt = 1'b1;
    w_pop       = '0;
    w_pos       = '0;
    w_restart   = 1'b0;

    for (int i = 0; i < int'(N_CH); i++) begin
      w_pop = w_pop + POP_W'(r_sw_deb[i]);
      if (r_sw_deb[i]) begin
        w_pos = SEL_W'(i);
      end
    end

    if (w_pop == POP_W'(1)) begin
      w_state_nxt = S_ON;
      w_idx_nxt   = w_pos;
    end else if (w_pop != POP_W'(0)) begin
      w_state_nxt = S_ERR;
    end

    // Blink restarts lit on entry to S_ON or on a channel change.
    w_restart = (w_state_nxt == S_ON) && ((r_state != S_ON) || (w_idx_nxt != r_idx));
    if ((w_state_nxt == S_ON) && !w_restart) begin
      if (r_blink_cnt == BLK_MAX) begin
        w_phase_nxt = ~r_phase;
      end else begin
        w_blink_nxt = r_blink_cnt + BLK_W'(1);
        w_phase_nxt = r_phase;
      end
    end
  end

  // Output decode from registered state; i_mode only gates the light.
  always_comb begin
    o_Light  = '0;
    o_sel    = r_idx;
    o_active = (r_state == S_ON);
    o_err    = (r_state == S_ERR);
    if ((r_state == S_ON) && (!i_mode || r_phase)) begin
      o_Light = N_CH'(1) << r_idx;
    end
  end

endmodule

// File: tb/tb_fsm_light_sel.sv
// Bench for fsm_light_sel: two instances (debounce 4 and 1) share stimulus and are
// compared every cycle against a stable-run / age-since-entry reference model.
module tb_fsm_light_sel;

  localparam int BH = 8;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       mode;

  logic [3:0] lt0, lt1;
  logic [1:0] sl0, sl1;
  logic       ac0, ac1, er0, er1;

  logic [3:0] lt [2];
  logic [1:0] sl [2];
  logic       ac [2];
  logic       er [2];
  assign lt[0] = lt0; assign lt[1] = lt1;
  assign sl[0] = sl0; assign sl[1] = sl1;
  assign ac[0] = ac0; assign ac[1] = ac1;
  assign er[0] = er0; assign er[1] = er1;

  fsm_light_sel #(.N_CH(4), .DEB_CYCLES(4), .BLINK_HALF(BH)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_OnOffSW(sw), .i_mode(mode),
    .o_Light(lt0), .o_sel(sl0), .o_active(ac0), .o_err(er0)
  );

  fsm_light_sel #(.N_CH(4), .DEB_CYCLES(1), .BLINK_HALF(BH)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_OnOffSW(sw), .i_mode(mode),
    .o_Light(lt1), .o_sel(sl1), .o_active(ac1), .o_err(er1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: accepted value = raw value seen on DEB+1 consecutive edges;
  // display follows accepted value one edge later; blink from age since entry.
  int         deb_v [2] = '{4, 1};
  logic [3:0] m_last [2];
  logic [3:0] m_acc  [2];
  int         m_run  [2];
  bit         m_on   [2];
  bit         m_err  [2];
  int         m_idx  [2];
  int         m_age  [2];

  function automatic logic [3:0] exp_lt(input int k);
    if (m_on[k] && (mode == 1'b0 || ((m_age[k] / BH) % 2) == 0))
      return 4'(1 << m_idx[k]);
    return 4'b0000;
  endfunction

  task automatic step(input logic [3:0] s, input logic md, input logic r);
    sw = s; mode = md; rst = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_last[k] = 4'b0; m_acc[k] = 4'b0; m_run[k] = deb_v[k] + 1;
        m_on[k] = 1'b0; m_err[k] = 1'b0; m_idx[k] = 0; m_age[k] = 0;
      end else begin
        int pc;
        int ni;
        pc = $countones(m_acc[k]);
        ni = (pc == 1) ? $clog2(m_acc[k]) : 0;
        if (pc == 1 && m_on[k] && ni == m_idx[k]) m_age[k]++;
        else m_age[k] = 0;
        m_on[k] = (pc == 1); m_err[k] = (pc >= 2); m_idx[k] = ni;
        if (s == m_last[k]) begin
          if (m_run[k] <= deb_v[k]) m_run[k]++;
        end else begin
          m_last[k] = s; m_run[k] = 1;
        end
        if (m_run[k] >= deb_v[k] + 1) m_acc[k] = m_last[k];
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(4'b0000, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if ({lt[k], sl[k], ac[k], er[k]} !== 8'h00) begin
          n_err++;
          $display("FAIL reset inst%0d c%0d: got l=%b s=%0d a=%b e=%b want all 0", k, c, lt[k], sl[k], ac[k], er[k]);
        end
      end
    end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 8; i++) begin
      step(4'b0010, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if ({lt[k], sl[k], ac[k], er[k]} !== {exp_lt(k), 2'(m_idx[k]), m_on[k], m_err[k]}) begin
          n_err++;
          $display("FAIL latency inst%0d E0+%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", k, i, lt[k], sl[k], ac[k], er[k], exp_lt(k), m_idx[k], m_on[k], m_err[k]);
        end
      end
      if (i == 4) begin
        n_vec++;
        if (lt0 !== 4'b0000) begin n_err++; $display("FAIL latency_early E0+4: got %b want 0000", lt0); end
      end
      if (i == 5) begin
        n_vec++;
        if ({lt0, sl0, ac0} !== {4'b0010, 2'd1, 1'b1}) begin
          n_err++; $display("FAIL latency_on E0+5: got %b/%0d/%b want 0010/1/1", lt0, sl0, ac0);
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 11; i++) begin
      step((i < 3) ? 4'b0110 : 4'b0010, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if ({lt[k], sl[k], ac[k], er[k]} !== {exp_lt(k), 2'(m_idx[k]), m_on[k], m_err[k]}) begin
          n_err++;
          $display("FAIL glitch inst%0d c%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", k, i, lt[k], sl[k], ac[k], er[k], exp_lt(k), m_idx[k], m_on[k], m_err[k]);
        end
      end
      n_vec++;
      if (lt0 !== 4'b0010 || er0 !== 1'b0) begin
        n_err++; $display("FAIL glitch_hold c%0d: got l=%b e=%b want 0010/0", i, lt0, er0);
      end
    end
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 18; i++) begin
      step((i < 10) ? 4'b0110 : 4'b0100, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if ({lt[k], sl[k], ac[k], er[k]} !== {exp_lt(k), 2'(m_idx[k]), m_on[k], m_err[k]}) begin
          n_err++;
          $display("FAIL conflict inst%0d c%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", k, i, lt[k], sl[k], ac[k], er[k], exp_lt(k), m_idx[k], m_on[k], m_err[k]);
        end
      end
    end
    n_vec++;
    if ({lt0, sl0, er0} !== {4'b0100, 2'd2, 1'b0}) begin
      n_err++; $display("FAIL conflict_release: got %b/%0d/%b want 0100/2/0", lt0, sl0, er0);
    end
  endtask

  task automatic test_blink();
    for (int i = 0; i < 70; i++) begin
      step((i < 40) ? 4'b1000 : 4'b0001, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if ({lt[k], sl[k], ac[k], er[k]} !== {exp_lt(k), 2'(m_idx[k]), m_on[k], m_err[k]}) begin
          n_err++;
          $display("FAIL blink inst%0d c%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", k, i, lt[k], sl[k], ac[k], er[k], exp_lt(k), m_idx[k], m_on[k], m_err[k]);
        end
      end
      // Dark half on ch3: dropping i_mode must relight without a clock edge.
      if (i == 20) begin
        mode = 1'b0;
        #1;
        n_vec++;
        if (lt0 !== 4'b1000) begin n_err++; $display("FAIL mode_immediate: got %b want 1000", lt0); end
        mode = 1'b1;
        #1;
        n_vec++;
        if (lt0 !== exp_lt(0)) begin n_err++; $display("FAIL mode_restore: got %b want %b", lt0, exp_lt(0)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq [12] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                             4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    for (int i = 0; i < 12; i++) begin
      step(seq[i], 1'b0, (i == 2) || (i == 10));
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if ({lt[k], sl[k], ac[k], er[k]} !== {exp_lt(k), 2'(m_idx[k]), m_on[k], m_err[k]}) begin
          n_err++;
          $display("FAIL reset_mid inst%0d c%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", k, i, lt[k], sl[k], ac[k], er[k], exp_lt(k), m_idx[k], m_on[k], m_err[k]);
        end
      end
      if (i == 2 || i == 10 || i == 7) begin
        n_vec++;
        if (lt0 !== 4'b0000 || ac0 !== 1'b0) begin
          n_err++; $display("FAIL reset_clear c%0d: got l=%b a=%b want 0000/0", i, lt0, ac0);
        end
      end
    end
  endtask

  task automatic test_deb1();
    for (int i = 0; i < 10; i++) begin
      step((i < 5) ? 4'b0001 : 4'b0100, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if ({lt[k], sl[k], ac[k], er[k]} !== {exp_lt(k), 2'(m_idx[k]), m_on[k], m_err[k]}) begin
          n_err++;
          $display("FAIL deb1 inst%0d c%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", k, i, lt[k], sl[k], ac[k], er[k], exp_lt(k), m_idx[k], m_on[k], m_err[k]);
        end
      end
      if (i >= 2) begin
        n_vec++;
        if (ac1 !== 1'b1) begin n_err++; $display("FAIL deb1_active c%0d: got %b want 1", i, ac1); end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    logic       md;
    int         hold;
    int         c;
    c = 0;
    while (c < 400) begin
      v    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      md   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        step(v, md, ($urandom_range(0, 99) == 0));
        c++;
        for (int k = 0; k < 2; k++) begin
          n_vec++;
          if ({lt[k], sl[k], ac[k], er[k]} !== {exp_lt(k), 2'(m_idx[k]), m_on[k], m_err[k]}) begin
            n_err++;
            $display("FAIL random inst%0d c%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", k, c, lt[k], sl[k], ac[k], er[k], exp_lt(k), m_idx[k], m_on[k], m_err[k]);
          end
        end
      end
    end
  endtask

  initial begin
    sw = 4'b0; mode = 1'b0; rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_conflict();
    test_blink();
    test_reset_mid();
    test_deb1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
